// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file writeback arbiter and RAW/WAW scoreboard
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   issue_valid_i/rd/rs1/rs2        instruction presented by the issue stage
//   issue_stall_o                   hazard: instruction not accepted this cycle
//   wb_valid_i/wb_rd_i/wb_data_i    per-source writeback requests (packed by source)
//   wb_ready_o                      one-hot round-robin grant
//   rf_we_o/rf_rd_addr_o/rf_rd_data_o  registered register-file write port
//   pending_cnt_o                   number of registers with a write outstanding
//   err_o                           sticky: writeback to a register that was not pending
module rf_wb_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid_i,
    input  logic [4:0]                    issue_rd_i,
    input  logic [4:0]                    issue_rs1_i,
    input  logic [4:0]                    issue_rs2_i,
    output logic                          issue_stall_o,
    input  logic [NUM_SRC-1:0]            wb_valid_i,
    input  logic [NUM_SRC*5-1:0]          wb_rd_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] wb_data_i,
    output logic [NUM_SRC-1:0]            wb_ready_o,
    output logic                          rf_we_o,
    output logic [4:0]                    rf_rd_addr_o,
    output logic [DATA_WIDTH-1:0]         rf_rd_data_o,
    output logic [5:0]                    pending_cnt_o,
    output logic                          err_o
);

    localparam int PTR_W = (NUM_SRC > 2) ? 2 : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [31:0]           pending_q, pending_d;
    logic [31:0]           clear_mask, eff_pending, set_mask;
    ptr_t                  rr_ptr_q, rr_ptr_d;
    ptr_t                  gnt_idx;
    logic                  gnt_any;
    logic [PTR_W:0]        scan;
    logic [NUM_SRC-1:0]    gnt_oh;
    logic [4:0]            gnt_rd;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  rf_we_q, rf_we_d;
    logic [4:0]            rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic                  err_q, err_d;
    logic [5:0]            cnt;

    // The register being written this cycle is covered by RF write-through,
    // so it is removed from the hazard view before the stall check.
    always_comb begin
        clear_mask = '0;
        if (rf_we_q) begin
            clear_mask[rf_addr_q] = 1'b1;
        end
        eff_pending = pending_q & ~clear_mask;
    end

    assign issue_stall_o = issue_valid_i &&
        (eff_pending[issue_rs1_i] | eff_pending[issue_rs2_i] | eff_pending[issue_rd_i]);

    // Set is OR-ed after the clear so a same-cycle re-issue leaves the bit set.
    always_comb begin
        set_mask = '0;
        if (issue_valid_i && !issue_stall_o && (issue_rd_i != 5'd0)) begin
            set_mask[issue_rd_i] = 1'b1;
        end
        pending_d = (eff_pending | set_mask) & ~32'h1;
    end

    // Round-robin search starting at rr_ptr; first valid source wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr_q;
        scan    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_SRC)) begin
                scan = scan - (PTR_W+1)'(NUM_SRC);
            end
            if (!gnt_any && wb_valid_i[scan[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        gnt_rd   = '0;
        gnt_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gnt_any && (gnt_idx == ptr_t'(k))) begin
                gnt_oh[k] = 1'b1;
                gnt_rd    = wb_rd_i[k*5 +: 5];
                gnt_data  = wb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wb_ready_o = gnt_oh;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt_any) begin
            rr_ptr_d  = (gnt_idx == ptr_t'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
            rf_addr_d = gnt_rd;
            rf_data_d = gnt_data;
        end
        // x0 writebacks are consumed silently: no write, no error.
        rf_we_d = gnt_any && (gnt_rd != 5'd0);
        err_d   = err_q | (rf_we_d && !eff_pending[gnt_rd]);
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(pending_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            err_q     <= err_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_rd_addr_o  = rf_addr_q;
    assign rf_rd_data_o  = rf_data_q;
    assign pending_cnt_o = cnt;
    assign err_o         = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

    localparam int DW = 32;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic [4:0]        issue_rd, issue_rs1, issue_rs2;
    logic              issue_stall_o;
    logic [NS-1:0]     wb_valid;
    logic [NS*5-1:0]   wb_rd;
    logic [NS*DW-1:0]  wb_data;
    logic [NS-1:0]     wb_ready_o;
    logic              rf_we_o;
    logic [4:0]        rf_rd_addr_o;
    logic [DW-1:0]     rf_rd_data_o;
    logic [5:0]        pending_cnt_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    bit [31:0]   m_pend;
    int          m_rr;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [DW-1:0] m_data;
    bit          m_err;

    rf_wb_scheduler #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_stall_o(issue_stall_o),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .wb_ready_o(wb_ready_o),
        .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
        .pending_cnt_o(pending_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        wb_valid = '0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic set_issue(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    task automatic set_wb(input int k, input bit [4:0] rd, input bit [DW-1:0] d);
        wb_valid[k] = 1'b1;
        wb_rd[k*5 +: 5] = rd;
        wb_data[k*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_pend = '0; m_rr = 0; m_we = 0; m_addr = '0; m_data = '0; m_err = 0;
    endtask

    // One cycle: compare DUT against the model, then advance the model.
    task automatic step();
        bit [31:0]   eff;
        bit          exp_stall;
        bit [NS-1:0] exp_rdy;
        bit [4:0]    grd;
        int          g;
        #1;
        eff = m_pend;
        if (m_we) eff[m_addr] = 1'b0;
        exp_stall = issue_valid && (eff[issue_rs1] || eff[issue_rs2] || eff[issue_rd]);
        g = -1;
        for (int i = 0; i < NS; i++) begin
            int k;
            k = (m_rr + i) % NS;
            if (g < 0 && wb_valid[k]) g = k;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("stall", issue_stall_o, exp_stall);
        chk("ready", wb_ready_o, exp_rdy);
        chk("rf_we", rf_we_o, m_we);
        chk("err", err_o, m_err);
        chk("pending_cnt", pending_cnt_o, $countones(m_pend));
        if (m_we) begin
            chk("rf_addr", rf_rd_addr_o, m_addr);
            chk("rf_data", rf_rd_data_o, m_data);
        end
        if (g >= 0) begin
            grd = wb_rd[g*5 +: 5];
            if (grd != 0 && !eff[grd]) m_err = 1'b1;
            m_we   = (grd != 0);
            m_addr = grd;
            m_data = wb_data[g*DW +: DW];
            m_rr   = (g + 1) % NS;
        end else begin
            m_we = 1'b0;
        end
        m_pend = eff;
        if (issue_valid && !exp_stall && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        set_issue(1, 0, 5, 0);
        wb_valid = 3'b010;
        #1;
        model_reset();
        chk("rst_cnt", pending_cnt_o, 0);
        chk("rst_we", rf_we_o, 0);
        chk("rst_addr", rf_rd_addr_o, 0);
        chk("rst_data", rf_rd_data_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stall", issue_stall_o, 0);
        chk("rst_ready", wb_ready_o, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    function automatic bit [4:0] pick_rd();
        int s;
        s = $urandom_range(0, 31);
        if ($urandom_range(0, 9) != 0) begin
            for (int i = 0; i < 32; i++) begin
                if (m_pend[(s + i) % 32]) return 5'((s + i) % 32);
            end
        end
        return 5'(s);
    endfunction

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            idle();
            set_issue($urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)),
                      5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 2) == 0) set_wb(k, pick_rd(), $urandom());
            end
            step();
        end
    endtask

    initial begin
        idle();
        do_reset();

        // RAW on x5, cleared via the clear mask the cycle rf_we is high
        set_issue(1, 5, 0, 0); step();
        idle(); set_issue(1, 10, 5, 0); set_wb(0, 5, 32'hDEADBEEF);
        #1;
        chk("t1_cnt", pending_cnt_o, 1);
        chk("t1_stall", issue_stall_o, 1);
        chk("t1_ready", wb_ready_o, 3'b001);
        step();
        idle(); set_issue(1, 10, 5, 0);
        #1;
        chk("t1_we", rf_we_o, 1);
        chk("t1_addr", rf_rd_addr_o, 5);
        chk("t1_data", rf_rd_data_o, 32'hDEADBEEF);
        chk("t1_unstall", issue_stall_o, 0);
        step();
        idle(); set_wb(1, 10, 32'h1234); step();
        idle(); step(); step();
        #1;
        chk("t1_cnt0", pending_cnt_o, 0);
        chk("t1_err0", err_o, 0);

        // round-robin over three concurrent writebacks
        do_reset();
        set_issue(1, 3, 0, 0); step();
        set_issue(1, 4, 0, 0); step();
        set_issue(1, 6, 0, 0); step();
        idle();
        set_wb(0, 3, 32'hA0); set_wb(1, 4, 32'hA1); set_wb(2, 6, 32'hA2);
        #1;
        chk("t2_cnt3", pending_cnt_o, 3);
        chk("t2_g0", wb_ready_o, 3'b001);
        step();
        wb_valid[0] = 1'b0; #1; chk("t2_g1", wb_ready_o, 3'b010); step();
        wb_valid[1] = 1'b0; #1; chk("t2_g2", wb_ready_o, 3'b100); step();
        idle(); step(); step();
        #1;
        chk("t2_cnt0", pending_cnt_o, 0);

        // re-issue of x7 while its clear is on the port: set wins
        set_issue(1, 7, 0, 0); step();
        idle(); set_wb(0, 7, 32'h77); step();
        idle(); set_issue(1, 7, 7, 0);
        #1;
        chk("t3_stall", issue_stall_o, 0);
        chk("t3_we", rf_we_o, 1);
        chk("t3_cnt", pending_cnt_o, 1);
        step();
        idle();
        #1;
        chk("t3_cnt_after", pending_cnt_o, 1);
        step();
        set_wb(0, 7, 32'h78); step();
        idle(); step(); step();

        // x0 issue and x0 writeback
        do_reset();
        set_issue(1, 0, 0, 0);
        #1; chk("t4_stall", issue_stall_o, 0);
        step();
        idle();
        #1; chk("t4_cnt", pending_cnt_o, 0);
        set_wb(2, 0, 32'h55);
        #1; chk("t4_ready", wb_ready_o, 3'b100);
        step();
        idle();
        #1;
        chk("t4_we", rf_we_o, 0);
        chk("t4_err", err_o, 0);
        step();

        // writeback to a non-pending register makes err sticky
        set_wb(0, 9, 32'h99); step();
        idle(); step();
        #1; chk("t5_err", err_o, 1);
        random_cycles(10);
        #1; chk("t5_err_sticky", err_o, 1);
        do_reset();

        // reset while a write is on the port
        set_issue(1, 1, 0, 0); step();
        set_issue(1, 2, 0, 0); step();
        set_issue(1, 3, 0, 0); step();
        idle(); set_wb(0, 1, 32'h11); step();
        idle();
        #1;
        chk("t6_we_pre", rf_we_o, 1);
        chk("t6_cnt_pre", pending_cnt_o, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_we", rf_we_o, 0);
        chk("t6_addr", rf_rd_addr_o, 0);
        chk("t6_data", rf_rd_data_o, 0);
        chk("t6_cnt", pending_cnt_o, 0);
        chk("t6_err", err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        random_cycles(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
